// File: rtl/dff_debounce_edge.sv
`default_nettype none
// ============================================================================
// Module   : dff_debounce_edge
// Brief    : Synchronise and debounce a raw bit; clean level, rise/fall
//            strobes and a saturating rising-edge counter.
// Revision : 1.0 - initial release
// ============================================================================
module dff_debounce_edge #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             d,
   input  logic             clear,
   output logic             q,
   output logic             rise,
   output logic             fall,
   output logic [CNT_W-1:0] edge_count,
   output logic             busy
);

   localparam int c_cnt_w = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
   // The cycle in STABLE_* that spots the mismatch is the first qualifying
   // cycle, so the check state finishes once cnt has reached DEBOUNCE_CYCLES-2.
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 2);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

   localparam logic [1:0] c_stable_lo = 2'd0;
   localparam logic [1:0] c_check_hi  = 2'd1;
   localparam logic [1:0] c_stable_hi = 2'd2;
   localparam logic [1:0] c_check_lo  = 2'd3;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_s;
   logic [1:0]             r_state, w_state_nxt;
   logic [c_cnt_w-1:0]     r_cnt, w_cnt_nxt;
   logic                   r_q, w_q_nxt;
   logic                   r_rise, w_rise_nxt;
   logic                   r_fall, w_fall_nxt;
   logic                   r_busy, w_busy_nxt;
   logic [CNT_W-1:0]       r_edge_count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], d};
      end
   end

   assign w_s = r_sync[SYNC_STAGES-1];

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= c_stable_lo;
         r_cnt   <= '0;
         r_q     <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_q     <= w_q_nxt;
         r_rise  <= w_rise_nxt;
         r_fall  <= w_fall_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      w_q_nxt     = r_q;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      case (r_state)
         c_stable_lo: begin
            if (w_s) begin
               if (DEBOUNCE_CYCLES == 2) begin
                  w_state_nxt = c_stable_hi;
                  w_q_nxt     = 1'b1;
                  w_rise_nxt  = 1'b1;
               end else begin
                  w_state_nxt = c_check_hi;
                  w_cnt_nxt   = c_cnt_one;
               end
            end
         end
         c_check_hi: begin
            if (!w_s) begin
               w_state_nxt = c_stable_lo;
            end else if (r_cnt == c_cnt_last) begin
               w_state_nxt = c_stable_hi;
               w_q_nxt     = 1'b1;
               w_rise_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + c_cnt_one;
            end
         end
         c_stable_hi: begin
            if (!w_s) begin
               if (DEBOUNCE_CYCLES == 2) begin
                  w_state_nxt = c_stable_lo;
                  w_q_nxt     = 1'b0;
                  w_fall_nxt  = 1'b1;
               end else begin
                  w_state_nxt = c_check_lo;
                  w_cnt_nxt   = c_cnt_one;
               end
            end
         end
         c_check_lo: begin
            if (w_s) begin
               w_state_nxt = c_stable_hi;
            end else if (r_cnt == c_cnt_last) begin
               w_state_nxt = c_stable_lo;
               w_q_nxt     = 1'b0;
               w_fall_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + c_cnt_one;
            end
         end
         default: begin
            w_state_nxt = c_stable_lo;
            w_q_nxt     = 1'b0;
         end
      endcase
   end

   // Output logic
   always_comb begin
      w_busy_nxt = 1'b0;
      if ((w_state_nxt == c_check_hi) || (w_state_nxt == c_check_lo)) begin
         w_busy_nxt = 1'b1;
      end
   end

   // Counts on the same edge that raises rise, so clear can override it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_edge_count <= '0;
      end else if (clear) begin
         r_edge_count <= '0;
      end else if (w_rise_nxt && (r_edge_count != {CNT_W{1'b1}})) begin
         r_edge_count <= r_edge_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign q          = r_q;
   assign rise       = r_rise;
   assign fall       = r_fall;
   assign busy       = r_busy;
   assign edge_count = r_edge_count;

endmodule
`default_nettype wire
